// File: rtl/bsg_reset_sequencer.sv
// rtl/bsg_reset_sequencer.sv - staged ready release after reset/restart with hold
// Optional: BSG_RESET_SEQUENCER_FAST_SIM_EN shortens each stage wait to 2^min(lg_wait_cycles_p,4).
module bsg_reset_sequencer #(
  parameter int els_p            = 4,
  parameter int lg_wait_cycles_p = 10,
  localparam int lg_els_lp       = ((els_p + 1) <= 1) ? 1 : $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 restart_i,
  input  logic                 hold_i,
  output logic [els_p-1:0]     ready_r_o,
  output logic [lg_els_lp-1:0] stage_r_o,
  output logic                 done_r_o
);

`ifdef BSG_RESET_SEQUENCER_FAST_SIM_EN
  localparam int lg_eff_lp = (lg_wait_cycles_p < 4) ? lg_wait_cycles_p : 4;
`else
  localparam int lg_eff_lp = lg_wait_cycles_p;
`endif

  localparam logic [lg_wait_cycles_p-1:0] term_lp =
    lg_wait_cycles_p'((64'd1 << lg_eff_lp) - 64'd1);
  localparam logic [lg_els_lp-1:0] els_lp  = lg_els_lp'(els_p);
  localparam logic [lg_els_lp-1:0] last_lp = lg_els_lp'(els_p - 1);

  typedef enum logic {COUNT, DONE} state_e;

  state_e                      state;
  logic [lg_wait_cycles_p-1:0] counter_q, counter_d;
  logic [lg_els_lp-1:0]        stage_q, stage_d;
  logic [els_p-1:0]            ready_q, ready_d;
  logic                        done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter_q <= '0;
      stage_q   <= '0;
      ready_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      stage_q   <= stage_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // State is implied by how many stages have been released.
  always_comb begin
    state     = (stage_q == els_lp) ? DONE : COUNT;
    counter_d = counter_q;
    stage_d   = stage_q;
    ready_d   = ready_q;
    done_d    = done_q;
    if (restart_i) begin
      counter_d = '0;
      stage_d   = '0;
      ready_d   = '0;
      done_d    = 1'b0;
    end else begin
      case (state)
        COUNT: begin
          if (!hold_i) begin
            if (counter_q == term_lp) begin
              counter_d = '0;
              stage_d   = stage_q + lg_els_lp'(1);
              // Shifting a 1 in keeps ready a contiguous thermometer code.
              ready_d   = (ready_q << 1) | els_p'(1);
              done_d    = (stage_q == last_lp);
            end else begin
              counter_d = counter_q + lg_wait_cycles_p'(1);
            end
          end
        end
        DONE: begin
          counter_d = '0;
        end
        default: begin
          counter_d = '0;
        end
      endcase
    end
  end

  assign ready_r_o = ready_q;
  assign stage_r_o = stage_q;
  assign done_r_o  = done_q;

endmodule

// File: tb/tb_bsg_reset_sequencer.sv
// tb/tb_bsg_reset_sequencer.sv - directed self-checking bench for bsg_reset_sequencer
module tb_bsg_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, restart_a, hold_a;
  logic [2:0] ready_a;
  logic [1:0] stage_a;
  logic       done_a;

  logic       reset_b, restart_b, hold_b;
  logic [0:0] ready_b;
  logic [0:0] stage_b;
  logic       done_b;

  logic       reset_c, restart_c, hold_c;
  logic [1:0] ready_c;
  logic [1:0] stage_c;
  logic       done_c;

  int checks = 0;
  int errors = 0;

`ifdef BSG_RESET_SEQUENCER_FAST_SIM_EN
  localparam int wait_c = 16;
`else
  localparam int wait_c = 1024;
`endif

  bsg_reset_sequencer #(.els_p(3), .lg_wait_cycles_p(2)) dut_a (
    .clk_i(clk), .reset_i(reset_a), .restart_i(restart_a), .hold_i(hold_a),
    .ready_r_o(ready_a), .stage_r_o(stage_a), .done_r_o(done_a)
  );

  bsg_reset_sequencer #(.els_p(1), .lg_wait_cycles_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_b), .restart_i(restart_b), .hold_i(hold_b),
    .ready_r_o(ready_b), .stage_r_o(stage_b), .done_r_o(done_b)
  );

  bsg_reset_sequencer #(.els_p(2), .lg_wait_cycles_p(10)) dut_c (
    .clk_i(clk), .reset_i(reset_c), .restart_i(restart_c), .hold_i(hold_c),
    .ready_r_o(ready_c), .stage_r_o(stage_c), .done_r_o(done_c)
  );

  // Expected stage count for dut_a after n counted edges (wait 4, 3 stages).
  function automatic int exp_stage_a(int n);
    int s;
    s = n / 4;
    if (s > 3) s = 3;
    return s;
  endfunction

  task automatic start_a();
    reset_a = 1'b1; restart_a = 1'b0; hold_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; restart_a = 1'b1; hold_a = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_a !== 3'b000 || stage_a !== 2'd0 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d ready %b want 000 stage %0d want 0 done %b want 0",
                 e, ready_a, stage_a, done_a);
      end
    end
  endtask

  task automatic test_sequence();
    int s;
    start_a();
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      s = exp_stage_a(e);
      checks++;
      if (ready_a !== 3'((1 << s) - 1) || stage_a !== 2'(s) || done_a !== (s == 3)) begin
        errors++;
        $display("FAIL sequence edge %0d ready %b stage %0d done %b want stage %0d",
                 e, ready_a, stage_a, done_a, s);
      end
    end
  endtask

  task automatic test_hold();
    int n, s;
    start_a();
    n = 0;
    for (int e = 1; e <= 24; e++) begin
      hold_a = (e >= 2 && e <= 6);
      @(posedge clk); #1;
      if (!hold_a) n++;
      s = exp_stage_a(n);
      checks++;
      if (ready_a !== 3'((1 << s) - 1) || stage_a !== 2'(s) || done_a !== (s == 3)) begin
        errors++;
        $display("FAIL hold edge %0d ready %b stage %0d done %b want stage %0d",
                 e, ready_a, stage_a, done_a, s);
      end
    end
    hold_a = 1'b0;
    checks++;
    if (ready_a !== 3'b111) begin
      errors++;
      $display("FAIL hold_final ready %b want 111", ready_a);
    end
  endtask

  task automatic test_restart();
    int n, s;
    start_a();
    n = 0;
    for (int e = 1; e <= 20; e++) begin
      restart_a = (e == 10 || e == 11);
      @(posedge clk); #1;
      if (restart_a) n = 0; else n++;
      s = exp_stage_a(n);
      checks++;
      if (ready_a !== 3'((1 << s) - 1) || stage_a !== 2'(s) || done_a !== (s == 3)) begin
        errors++;
        $display("FAIL restart edge %0d ready %b stage %0d done %b want stage %0d",
                 e, ready_a, stage_a, done_a, s);
      end
    end
    restart_a = 1'b0;
  endtask

  task automatic test_restart_priority();
    start_a();
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (ready_a !== 3'b001) begin
      errors++;
      $display("FAIL prio_pre ready %b want 001", ready_a);
    end
    // counter is at 3 here: this edge would release stage 1 without restart
    restart_a = 1'b1; hold_a = 1'b1;
    @(posedge clk); #1;
    restart_a = 1'b0; hold_a = 1'b0;
    checks++;
    if (ready_a !== 3'b000 || stage_a !== 2'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL prio_restart_hold ready %b want 000 stage %0d want 0", ready_a, stage_a);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_a !== 3'b000) begin
      errors++;
      $display("FAIL prio_after3 ready %b want 000", ready_a);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_a !== 3'b001 || stage_a !== 2'd1) begin
      errors++;
      $display("FAIL prio_after4 ready %b want 001 stage %0d want 1", ready_a, stage_a);
    end
    repeat (5) @(posedge clk);
    #1;
    reset_a = 1'b1; restart_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0; restart_a = 1'b0;
    checks++;
    if (ready_a !== 3'b000 || stage_a !== 2'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL prio_reset_restart ready %b want 000 stage %0d want 0", ready_a, stage_a);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ready_a !== 3'b001) begin
      errors++;
      $display("FAIL prio_rerun ready %b want 001", ready_a);
    end
  endtask

  task automatic test_single_stage();
    reset_b = 1'b1; hold_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_b !== 1'b0 || done_b !== 1'b0 || stage_b !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1 ready %b want 0 done %b want 0", ready_b, done_b);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_b !== 1'b1 || done_b !== 1'b1 || stage_b !== 1'b1) begin
      errors++;
      $display("FAIL single_edge2 ready %b want 1 done %b want 1 stage %0d want 1",
               ready_b, done_b, stage_b);
    end
    for (int e = 0; e < 6; e++) begin
      hold_b = e[0];
      @(posedge clk); #1;
      checks++;
      if (ready_b !== 1'b1 || done_b !== 1'b1 || stage_b !== 1'b1) begin
        errors++;
        $display("FAIL single_done_hold %0d ready %b done %b stage %0d want 1 1 1",
                 e, ready_b, done_b, stage_b);
      end
    end
    hold_b = 1'b0;
  endtask

  task automatic test_long_wait();
    int s;
    reset_c = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_c = 1'b0;
    for (int e = 1; e <= 2 * wait_c + 10; e++) begin
      @(posedge clk); #1;
      if (e == wait_c - 1 || e == wait_c || e == 2 * wait_c - 1 ||
          e == 2 * wait_c || e == 2 * wait_c + 10) begin
        s = e / wait_c;
        if (s > 2) s = 2;
        checks++;
        if (ready_c !== 2'((1 << s) - 1) || stage_c !== 2'(s) || done_c !== (s == 2)) begin
          errors++;
          $display("FAIL long_wait edge %0d ready %b stage %0d done %b want stage %0d",
                   e, ready_c, stage_c, done_c, s);
        end
      end
    end
  endtask

  initial begin
    reset_a = 1'b1; restart_a = 1'b0; hold_a = 1'b0;
    reset_b = 1'b1; restart_b = 1'b0; hold_b = 1'b0;
    reset_c = 1'b1; restart_c = 1'b0; hold_c = 1'b0;
    test_reset();
    test_sequence();
    test_hold();
    test_restart();
    test_restart_priority();
    test_single_stage();
    test_long_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
